// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester handshakes, uart_tx byte port and status of the arbiter
interface uart_tx_arbiter_if;
   logic        req0_valid;
   logic [31:0] req0_data;
   logic        req0_ack;
   logic        req1_valid;
   logic [31:0] req1_data;
   logic        req1_ack;
   logic [7:0]  tx_data;
   logic        tx_read_clock_enable;
   logic        tx_ready;
   logic        busy;
   logic [15:0] frame_count;

   modport master (
      output req0_valid, req0_data, req1_valid, req1_data, tx_ready,
      input  req0_ack, req1_ack, tx_data, tx_read_clock_enable, busy, frame_count
   );

   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data, tx_ready,
      output req0_ack, req1_ack, tx_data, tx_read_clock_enable, busy, frame_count
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin framing of two 32-bit requesters onto a byte-wide uart_tx
module uart_tx_arbiter #(
   parameter logic [7:0] SYNC_BYTE = 8'h7E,
   parameter bit         SEND_ID   = 1'b1
) (
   input logic               clk_i,
   input logic               rst_ni,
   uart_tx_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, OFFER, WAIT_LOW, WAIT_HIGH} state_t;

   localparam logic [2:0] LAST_IDX = SEND_ID ? 3'd5 : 3'd4;
   localparam logic [2:0] DATA_OFS = SEND_ID ? 3'd2 : 3'd1;

   state_t      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [31:0] word_q, word_d;
   logic        id_q, id_d;
   logic        last_q, last_d;
   logic        ack0_q, ack0_d;
   logic        ack1_q, ack1_d;
   logic        en_q, en_d;
   logic        busy_q, busy_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic [15:0] count_q, count_d;
   logic        grant1;

   // Byte i of the frame: sync, optional requester ID, then the word MSB first.
   function automatic logic [7:0] frame_byte(input logic [2:0] i, input logic [31:0] w, input logic id);
      logic [2:0]  k;
      logic [31:0] sh;
      k = i - DATA_OFS;
      sh = w >> {~k[1:0], 3'b000};
      frame_byte = (i == 3'd0) ? SYNC_BYTE : (SEND_ID && i == 3'd1) ? {7'd0, id} : sh[7:0];
   endfunction

   // Requester 1 wins when alone, or on a tie when requester 0 was granted last.
   assign grant1 = bus.req1_valid & (~bus.req0_valid | ~last_q);

   // Next-state and registered-output logic of the framing FSM.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      word_d    = word_q;
      id_d      = id_q;
      last_d    = last_q;
      ack0_d    = 1'b0;
      ack1_d    = 1'b0;
      en_d      = en_q;
      tx_data_d = tx_data_q;
      count_d   = count_q;
      case (state_q)
         IDLE:
            if (bus.req0_valid | bus.req1_valid) begin
               state_d   = OFFER;
               idx_d     = 3'd0;
               word_d    = grant1 ? bus.req1_data : bus.req0_data;
               id_d      = grant1;
               last_d    = grant1;
               ack0_d    = ~grant1;
               ack1_d    = grant1;
               en_d      = 1'b1;
               tx_data_d = SYNC_BYTE;
            end
         OFFER:
            if (bus.tx_ready) begin
               state_d = WAIT_LOW;
               en_d    = 1'b0;
            end
         WAIT_LOW:
            if (!bus.tx_ready) state_d = WAIT_HIGH;
         WAIT_HIGH:
            if (bus.tx_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = IDLE;
                  count_d = count_q + 16'd1;
               end else begin
                  state_d   = OFFER;
                  idx_d     = idx_q + 3'd1;
                  en_d      = 1'b1;
                  tx_data_d = frame_byte(idx_q + 3'd1, word_q, id_q);
               end
            end
         default: state_d = IDLE;
      endcase
      busy_d = state_d != IDLE;
   end

   // State and output registers; reset abandons any frame in progress.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         idx_q     <= 3'd0;
         word_q    <= 32'd0;
         id_q      <= 1'b0;
         last_q    <= 1'b1;
         ack0_q    <= 1'b0;
         ack1_q    <= 1'b0;
         en_q      <= 1'b0;
         busy_q    <= 1'b0;
         tx_data_q <= 8'h00;
         count_q   <= 16'd0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         word_q    <= word_d;
         id_q      <= id_d;
         last_q    <= last_d;
         ack0_q    <= ack0_d;
         ack1_q    <= ack1_d;
         en_q      <= en_d;
         busy_q    <= busy_d;
         tx_data_q <= tx_data_d;
         count_q   <= count_d;
      end
   end

   assign bus.req0_ack             = ack0_q;
   assign bus.req1_ack             = ack1_q;
   assign bus.tx_data              = tx_data_q;
   assign bus.tx_read_clock_enable = en_q;
   assign bus.busy                 = busy_q;
   assign bus.frame_count          = count_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: table vectors, corner sequences and randomized traffic against a frame-level model
module tb_uart_tx_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_tx_arbiter_if b1();
   uart_tx_arbiter_if b0();

   uart_tx_arbiter dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(b1));
   uart_tx_arbiter #(.SYNC_BYTE(8'h7E), .SEND_ID(1'b0)) dut0 (.clk_i(clk), .rst_ni(rst_n), .bus(b0));

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic timeout(input string name);
      tests++;
      fails++;
      $display("FAIL %s: timed out", name);
   endtask

   // Frame-level model and uart_tx behaviour for the SEND_ID=1 instance.
   logic [7:0]  exp_q[$];
   int          caps = 0;
   int          frames_m = 0;
   bit          last_m = 1'b1;
   bit          hold = 1'b0;
   logic        prev_busy = 1'b0, prev_en = 1'b0;
   logic [7:0]  prev_data = 8'h00;
   int          acc = 0, cnt = 0;

   initial begin
      bit          pred;
      logic [31:0] w;
      b1.tx_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            b1.tx_ready = 1'b1;
            acc = 0;
            cnt = 0;
            exp_q.delete();
            last_m = 1'b1;
            frames_m = 0;
            prev_busy = 1'b0;
            prev_en = 1'b0;
            prev_data = 8'h00;
         end else begin
            check("ack_onehot", {31'd0, b1.req0_ack & b1.req1_ack}, 32'd0);
            check("ack_in_frame", {31'd0, (b1.req0_ack | b1.req1_ack) & prev_busy}, 32'd0);
            if (b1.req0_ack | b1.req1_ack) begin
               pred = (b1.req0_valid && b1.req1_valid) ? !last_m : b1.req1_valid;
               check("grant_rr", {31'd0, b1.req1_ack}, {31'd0, pred});
               check("lat_busy", {31'd0, b1.busy}, 32'd1);
               check("lat_en", {31'd0, b1.tx_read_clock_enable}, 32'd1);
               check("lat_sync", {24'd0, b1.tx_data}, 32'h7E);
               w = pred ? b1.req1_data : b1.req0_data;
               exp_q.push_back(8'h7E);
               exp_q.push_back({7'd0, pred});
               for (int k = 3; k >= 0; k--) exp_q.push_back(w[8*k +: 8]);
               last_m = pred;
               frames_m++;
            end
            if (prev_busy && b1.busy && !(b1.tx_read_clock_enable && !prev_en))
               check("tx_stable", {24'd0, b1.tx_data}, {24'd0, prev_data});
            if (acc != 0) begin
               b1.tx_ready = 1'b0;
               cnt = $urandom_range(1, 4);
               acc = 0;
            end else if (cnt > 0) begin
               cnt--;
               if (cnt == 0) b1.tx_ready = 1'b1;
            end else if (hold) begin
               b1.tx_ready = 1'b0;
            end else begin
               b1.tx_ready = 1'b1;
               if (b1.tx_read_clock_enable) begin
                  caps++;
                  if (exp_q.size() == 0) check("unexpected_byte", {24'd0, b1.tx_data}, 32'hFFFF_FFFF);
                  else check("byte", {24'd0, b1.tx_data}, {24'd0, exp_q.pop_front()});
                  acc = 1;
               end
            end
            prev_busy = b1.busy;
            prev_en = b1.tx_read_clock_enable;
            prev_data = b1.tx_data;
         end
      end
   end

   // Fixed-delay uart_tx stand-in for the SEND_ID=0 instance.
   logic [7:0] got0[$];
   int         pulses0 = 0, a0 = 0, c0 = 0;
   logic       prev_en0 = 1'b0;

   initial begin
      b0.tx_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            b0.tx_ready = 1'b1;
            a0 = 0;
            c0 = 0;
            pulses0 = 0;
            got0.delete();
            prev_en0 = 1'b0;
         end else begin
            if (b0.tx_read_clock_enable && !prev_en0) pulses0++;
            if (a0 != 0) begin
               b0.tx_ready = 1'b0;
               c0 = 2;
               a0 = 0;
            end else if (c0 > 0) begin
               c0--;
               if (c0 == 0) b0.tx_ready = 1'b1;
            end else begin
               b0.tx_ready = 1'b1;
               if (b0.tx_read_clock_enable) begin
                  got0.push_back(b0.tx_data);
                  a0 = 1;
               end
            end
            prev_en0 = b0.tx_read_clock_enable;
         end
      end
   end

   task automatic wait_ack(output bit g);
      bit ok = 1'b0;
      g = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (b1.req0_ack | b1.req1_ack) begin
            g = b1.req1_ack;
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeout("ack");
   endtask

   task automatic wait_idle(input int lim);
      bit ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if (!b1.busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeout("idle");
   endtask

   task automatic run_vec(input bit v0, input bit v1, input logic [31:0] d0, input logic [31:0] d1, output bit g);
      @(negedge clk);
      #1;
      b1.req0_valid = v0;
      b1.req1_valid = v1;
      b1.req0_data = d0;
      b1.req1_data = d1;
      wait_ack(g);
      #1;
      b1.req0_valid = 1'b0;
      b1.req1_valid = 1'b0;
      b1.req0_data = ~d0;
      b1.req1_data = ~d1;
      wait_idle(400);
   endtask

   typedef struct {
      bit          v0;
      bit          v1;
      logic [31:0] d0;
      logic [31:0] d1;
      bit          exp1;
      logic [15:0] expcnt;
   } vec_t;

   vec_t        vt[8];
   logic [31:0] q0[$], q1[$];

   initial begin
      bit         g;
      int         n, start, c1;
      bit         ok;
      logic [7:0] exp0[5];
      vt[0] = '{1'b1, 1'b0, 32'hDEADBEEF, 32'h00000000, 1'b0, 16'd1};
      vt[1] = '{1'b1, 1'b1, 32'h12345678, 32'h89ABCDEF, 1'b1, 16'd2};
      vt[2] = '{1'b1, 1'b1, 32'h00000000, 32'hFFFFFFFF, 1'b0, 16'd3};
      vt[3] = '{1'b0, 1'b1, 32'h00000000, 32'hA5A55A5A, 1'b1, 16'd4};
      vt[4] = '{1'b0, 1'b1, 32'h00000000, 32'h00FF00FF, 1'b1, 16'd5};
      vt[5] = '{1'b1, 1'b1, 32'h13579BDF, 32'h2468ACE0, 1'b0, 16'd6};
      vt[6] = '{1'b1, 1'b0, 32'h80000001, 32'h00000000, 1'b0, 16'd7};
      vt[7] = '{1'b1, 1'b1, 32'h7E7E7E7E, 32'h01010101, 1'b1, 16'd8};
      b1.req0_valid = 1'b0;
      b1.req1_valid = 1'b0;
      b1.req0_data = 32'd0;
      b1.req1_data = 32'd0;
      b0.req0_valid = 1'b0;
      b0.req1_valid = 1'b0;
      b0.req0_data = 32'd0;
      b0.req1_data = 32'd0;

      #20;
      check("rst_busy", {31'd0, b1.busy}, 32'd0);
      check("rst_en", {31'd0, b1.tx_read_clock_enable}, 32'd0);
      check("rst_data", {24'd0, b1.tx_data}, 32'd0);
      check("rst_ack0", {31'd0, b1.req0_ack}, 32'd0);
      check("rst_ack1", {31'd0, b1.req1_ack}, 32'd0);
      check("rst_count", {16'd0, b1.frame_count}, 32'd0);
      check("rst_en_id0", {31'd0, b0.tx_read_clock_enable}, 32'd0);
      @(negedge clk);
      #1 rst_n = 1'b1;

      foreach (vt[i]) begin
         run_vec(vt[i].v0, vt[i].v1, vt[i].d0, vt[i].d1, g);
         check($sformatf("vec%0d_grant", i), {31'd0, g}, {31'd0, vt[i].exp1});
         check($sformatf("vec%0d_count", i), {16'd0, b1.frame_count}, {16'd0, vt[i].expcnt});
      end

      @(negedge clk);
      #1;
      hold = 1'b1;
      b1.req0_valid = 1'b1;
      b1.req0_data = 32'hCAFEF00D;
      wait_ack(g);
      #1 b1.req0_valid = 1'b0;
      b1.req0_data = 32'h0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         check("hold_en", {31'd0, b1.tx_read_clock_enable}, 32'd1);
         check("hold_data", {24'd0, b1.tx_data}, 32'h7E);
      end
      #1 hold = 1'b0;
      wait_idle(400);
      check("hold_count", {16'd0, b1.frame_count}, 32'd9);

      for (int r = 0; r < 4; r++) begin
         n = 0;
         start = frames_m;
         repeat ($urandom_range(0, 4)) begin q0.push_back($urandom); n++; end
         repeat ($urandom_range(1, 4)) begin q1.push_back($urandom); n++; end
         ok = 1'b0;
         for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (b1.req0_ack && q0.size() > 0) void'(q0.pop_front());
            if (b1.req1_ack && q1.size() > 0) void'(q1.pop_front());
            #1;
            b1.req0_valid = q0.size() > 0;
            b1.req1_valid = q1.size() > 0;
            b1.req0_data = (q0.size() > 0) ? q0[0] : $urandom;
            b1.req1_data = (q1.size() > 0) ? q1[0] : $urandom;
            if (q0.size() == 0 && q1.size() == 0 && !b1.busy) begin
               ok = 1'b1;
               break;
            end
         end
         if (!ok) timeout("rand_drain");
         wait_idle(400);
         check("rand_frames", frames_m - start, n);
         check("rand_count", {16'd0, b1.frame_count}, frames_m);
         check("rand_leftover", exp_q.size(), 0);
      end

      @(negedge clk);
      force dut1.count_q = 16'hFFFF;
      @(negedge clk);
      release dut1.count_q;
      check("preload", {16'd0, b1.frame_count}, 32'hFFFF);
      run_vec(1'b1, 1'b0, 32'h55AA55AA, 32'h0, g);
      check("wrap_count", {16'd0, b1.frame_count}, 32'h0);

      c1 = caps;
      @(negedge clk);
      #1 b1.req1_valid = 1'b1;
      b1.req1_data = 32'h11223344;
      wait_ack(g);
      #1 b1.req1_valid = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (caps == c1 + 3) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeout("third_byte");
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", {31'd0, b1.busy}, 32'd0);
      check("mid_rst_en", {31'd0, b1.tx_read_clock_enable}, 32'd0);
      check("mid_rst_data", {24'd0, b1.tx_data}, 32'd0);
      check("mid_rst_acks", {30'd0, b1.req0_ack, b1.req1_ack}, 32'd0);
      check("mid_rst_count", {16'd0, b1.frame_count}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      #1 rst_n = 1'b1;
      c1 = caps;
      repeat (30) @(negedge clk);
      check("no_retx", caps, c1);
      check("post_rst_busy", {31'd0, b1.busy}, 32'd0);
      check("post_rst_count", {16'd0, b1.frame_count}, 32'd0);
      run_vec(1'b1, 1'b1, 32'h0BADF00D, 32'hFEEDFACE, g);
      check("post_rst_grant", {31'd0, g}, 32'd0);
      check("post_rst_count1", {16'd0, b1.frame_count}, 32'd1);

      exp0[0] = 8'h7E;
      exp0[1] = 8'h01;
      exp0[2] = 8'h02;
      exp0[3] = 8'h03;
      exp0[4] = 8'h04;
      @(negedge clk);
      #1 b0.req1_valid = 1'b1;
      b0.req1_data = 32'h01020304;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (b0.req1_ack) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeout("noid_ack");
      #1 b0.req1_valid = 1'b0;
      b0.req1_data = 32'hFFFFFFFF;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (!b0.busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeout("noid_idle");
      check("noid_len", got0.size(), 5);
      check("noid_pulses", pulses0, 5);
      check("noid_count", {16'd0, b0.frame_count}, 32'd1);
      for (int i = 0; i < 5; i++)
         check($sformatf("noid_byte%0d", i), (i < got0.size()) ? {24'd0, got0[i]} : 32'hFFFF_FFFF, {24'd0, exp0[i]});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter SYNC_BYTE, default 8'h7E: first byte of every frame.
REQ-002 Parameter SEND_ID, default 1: 1 = frame carries a requester-ID byte after SYNC_BYTE; 0 = ID byte omitted.
REQ-003 Port clock  input  1  single system clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port req0_valid  input  1  requester 0 has a 32-bit word pending.
REQ-006 Port req0_data  input  32  requester 0 word.
REQ-007 Port req0_ack  output  1  one-cycle pulse: req0_data captured.
REQ-008 Port req1_valid / req1_data / req1_ack  input 1 / input 32 / output 1  same as requester 0.
REQ-009 Port tx_data  output  8  byte presented to uart_tx read_data.
REQ-010 Port tx_read_clock_enable  output  1  drives uart_tx read_clock_enable; byte offered.
REQ-011 Port tx_ready  input  1  uart_tx ready; high = idle, able to accept a byte.
REQ-012 Port busy  output  1  high whenever a frame is in progress (state != IDLE).
REQ-013 Port frame_count  output  16  completed frames, modulo 2^16.

Function
REQ-014 The block SHALL send frames: SYNC_BYTE, [ID byte 8'h00 or 8'h01 if SEND_ID=1], data[31:24], data[23:16], data[15:8], data[7:0]; 6 bytes with SEND_ID=1, 5 with SEND_ID=0.
REQ-015 The FSM SHALL have states IDLE, OFFER, WAIT_LOW, WAIT_HIGH; all outputs registered.
REQ-016 IDLE: if any reqN_valid is high at an edge, the block SHALL grant, capture reqN_data and the ID into internal registers, pulse reqN_ack high for exactly the next cycle, set byte index 0, and enter OFFER.
REQ-017 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it; last-grant register resets to 1 so requester 0 wins the first tie.
REQ-018 OFFER: tx_read_clock_enable SHALL be high and tx_data SHALL hold the indexed byte; on an edge with tx_ready=1 the byte is accepted, enable drops next cycle, state goes WAIT_LOW.
REQ-019 WAIT_LOW: tx_read_clock_enable low; on an edge with tx_ready=0 go to WAIT_HIGH.
REQ-020 WAIT_HIGH: on an edge with tx_ready=1: if the byte was the last of the frame, increment frame_count and go IDLE; else increment index and go OFFER.
REQ-021 tx_data SHALL remain stable from entering OFFER until leaving WAIT_HIGH.
REQ-022 Latency: valid sampled at edge k -> ack, busy, tx_read_clock_enable and tx_data=SYNC_BYTE all high/valid during cycle k+1.
REQ-023 A reqN_valid arriving while busy SHALL stay pending without ack until the next IDLE grant; the earliest next grant is the edge after returning to IDLE.
REQ-024 Deassertion of reqN_valid or change of reqN_data after ack SHALL not affect the frame in progress.
REQ-025 frame_count SHALL wrap 16'hFFFF -> 16'h0000 without side effects.
REQ-026 At most one reqN_ack SHALL be high in any cycle; never while a frame is in progress past its first cycle.

Reset
REQ-027 reset low SHALL immediately force state IDLE, tx_read_clock_enable=0, tx_data=8'h00, req0_ack=req1_ack=0, busy=0, frame_count=0, byte index 0, last grant=1.
REQ-028 Reset asserted mid-frame SHALL abandon the frame; after release the block SHALL resume from IDLE and not retransmit the abandoned word.

Verification
REQ-029 req0_valid, data 32'hDEADBEEF, uart_tx model toggling ready -> req0_ack one pulse, serial bytes 7E 00 DE AD BE EF, frame_count=1.
REQ-030 req0 and req1 valid together from reset, held -> frames alternate ID 00, 01, 00, 01; one ack per frame.
REQ-031 SEND_ID=0, req1 data 32'h01020304 -> bytes 7E 01 02 03 04, 5 enable pulses.
REQ-032 tx_ready held low for 50 cycles in OFFER -> enable stays high, tx_data stable, no progress; release -> frame completes.
REQ-033 Reset low after 3rd byte accepted -> outputs zero same cycle; after release, no bytes until a new valid; frame_count=0.
REQ-034 Preload frame_count to 16'hFFFF via 65535 short frames (or force) then one frame -> frame_count=16'h0000.
